// File: rtl/mem_io_ctrl_pkg.sv
// rtl/mem_io_ctrl_pkg.sv - shared state encodings and constants for the MEM-stage IO controller
package mem_io_ctrl_pkg;

    typedef enum logic [2:0] {
        MIO_IDLE      = 3'd0,
        MIO_WAIT_FREE = 3'd1,
        MIO_START     = 3'd2,
        MIO_WAIT_RDY  = 3'd3,
        MIO_DONE      = 3'd4
    } mio_state_e;

    localparam logic [31:0] MIO_ERR_VAL = 32'hDEADBEEF;

    // Bit positions of the status word returned by a status read
    localparam int IO_ST_READY = 0;
    localparam int IO_ST_BUSY  = 1;

endpackage

// File: rtl/mem_io_ctrl_if.sv
// rtl/mem_io_ctrl_if.sv - pipeline request, DCache and IO channel signals of the MEM-stage controller
interface mem_io_ctrl_if #(
    parameter int WIDTH   = 32,
    parameter int N_CH    = 4,
    parameter int CH_BITS = 2
);
    logic                  req_valid;
    logic [1:0]            req_is_dmem;
    logic                  req_is_io;
    logic                  req_is_state;
    logic [CH_BITS-1:0]    req_ch;
    logic [WIDTH-1:0]      wdata;
    logic                  mem_adv;
    logic                  pipe_flush;
    logic                  dc_ready;
    logic [WIDTH-1:0]      dc_rdata;
    logic [N_CH-1:0]       io_busy;
    logic [N_CH-1:0]       io_ready;
    logic [N_CH*WIDTH-1:0] io_rdata;
    logic [N_CH-1:0]       io_start;
    logic [N_CH-1:0]       io_clear;
    logic [WIDTH-1:0]      io_wdata;
    logic [WIDTH-1:0]      data_out;
    logic                  stall;
    logic                  flush_out;
    logic                  io_err;

    modport master (
        output req_valid, req_is_dmem, req_is_io, req_is_state, req_ch, wdata,
        output mem_adv, pipe_flush, dc_ready, dc_rdata, io_busy, io_ready, io_rdata,
        input  io_start, io_clear, io_wdata, data_out, stall, flush_out, io_err
    );

    modport slave (
        input  req_valid, req_is_dmem, req_is_io, req_is_state, req_ch, wdata,
        input  mem_adv, pipe_flush, dc_ready, dc_rdata, io_busy, io_ready, io_rdata,
        output io_start, io_clear, io_wdata, data_out, stall, flush_out, io_err
    );
endinterface

// File: rtl/mem_io_ctrl_io_ch_sel.sv
// rtl/mem_io_ctrl_io_ch_sel.sv - channel index to one-hot decoder plus read-data mux
module mem_io_ctrl_io_ch_sel #(
    parameter int WIDTH   = 32,
    parameter int N_CH    = 4,
    parameter int CH_BITS = 2
) (
    input  logic [CH_BITS-1:0]    ch,
    input  logic [N_CH*WIDTH-1:0] rdata_bus,
    output logic [N_CH-1:0]       ch_oh,
    output logic [WIDTH-1:0]      rdata
);
    // An index beyond N_CH decodes to all-zero, which the FSM treats as a bad channel
    always_comb begin
        ch_oh = '0;
        rdata = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch == CH_BITS'(k)) begin
                ch_oh[k] = 1'b1;
                rdata    = rdata_bus[k*WIDTH +: WIDTH];
            end
        end
    end
endmodule

// File: rtl/mem_io_ctrl.sv
// rtl/mem_io_ctrl.sv - MEM-stage DCache pass-through, IO status read and IO channel handshake FSM
module mem_io_ctrl
    import mem_io_ctrl_pkg::*;
#(
    parameter int          WIDTH   = 32,
    parameter int          N_CH    = 4,
    parameter int          CH_BITS = 2,
    parameter int          TIMEOUT = 255,
    parameter logic [31:0] ERR_VAL = MIO_ERR_VAL
) (
    input  logic         clk,
    input  logic         rst,
    mem_io_ctrl_if.slave bus
);
    localparam int               CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [WIDTH-1:0] ERR_W   = WIDTH'(ERR_VAL);

    mio_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               err_q, err_d;
    logic [CH_BITS-1:0] ch_q, ch_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;

    logic               is_dc_req, is_st_req, is_io_req;
    logic [CH_BITS-1:0] ch_cur;
    logic [N_CH-1:0]    ch_oh;
    logic [WIDTH-1:0]   ch_rdata;
    logic               busy_sel, ready_sel;

    logic               stall_c, io_err_c;
    logic [WIDTH-1:0]   data_out_c;
    logic [N_CH-1:0]    start_c, clear_c;

    assign is_dc_req = bus.req_valid && (|bus.req_is_dmem) && !bus.req_is_io;
    assign is_st_req = bus.req_valid && bus.req_is_io && bus.req_is_state;
    assign is_io_req = bus.req_valid && bus.req_is_io && !bus.req_is_state && (|bus.req_is_dmem);

    // Live request channel while idle; the latched channel once a handshake is under way
    assign ch_cur = (state_q == MIO_IDLE) ? bus.req_ch : ch_q;

    mem_io_ctrl_io_ch_sel #(
        .WIDTH   (WIDTH),
        .N_CH    (N_CH),
        .CH_BITS (CH_BITS)
    ) u_ch_sel (
        .ch        (ch_cur),
        .rdata_bus (bus.io_rdata),
        .ch_oh     (ch_oh),
        .rdata     (ch_rdata)
    );

    assign busy_sel  = |(bus.io_busy & ch_oh);
    assign ready_sel = |(bus.io_ready & ch_oh);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= MIO_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            ch_q     <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
            ch_q     <= ch_d;
            wdata_q  <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        err_d      = err_q;
        ch_d       = ch_q;
        wdata_d    = wdata_q;
        stall_c    = 1'b0;
        io_err_c   = 1'b0;
        data_out_c = '0;
        start_c    = '0;
        clear_c    = '0;

        case (state_q)
            MIO_IDLE: begin
                if (is_dc_req) begin
                    stall_c    = !bus.dc_ready;
                    data_out_c = bus.dc_rdata;
                end else if (is_st_req) begin
                    data_out_c[IO_ST_BUSY]  = busy_sel;
                    data_out_c[IO_ST_READY] = ready_sel;
                end else if (is_io_req) begin
                    stall_c = 1'b1;
                    ch_d    = bus.req_ch;
                    wdata_d = bus.wdata;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    if (ch_oh == '0) begin
                        state_d  = MIO_DONE;
                        err_d    = 1'b1;
                        result_d = ERR_W;
                    end else if (busy_sel) begin
                        state_d = MIO_WAIT_FREE;
                    end else begin
                        state_d = MIO_START;
                    end
                end
            end
            MIO_WAIT_FREE: begin
                stall_c = 1'b1;
                if (!busy_sel) begin
                    state_d = MIO_START;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = MIO_DONE;
                    err_d    = 1'b1;
                    result_d = ERR_W;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MIO_START: begin
                stall_c = 1'b1;
                start_c = ch_oh;
                state_d = MIO_WAIT_RDY;
                cnt_d   = '0;
            end
            MIO_WAIT_RDY: begin
                stall_c = 1'b1;
                if (ready_sel) begin
                    result_d = ch_rdata;
                    clear_c  = ch_oh;
                    state_d  = MIO_DONE;
                end else if (cnt_q == CNT_MAX) begin
                    result_d = ERR_W;
                    err_d    = 1'b1;
                    clear_c  = ch_oh;
                    state_d  = MIO_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MIO_DONE: begin
                // Held until the pipeline actually advances so a frozen MEM stage cannot re-issue
                data_out_c = result_q;
                io_err_c   = err_q;
                if (bus.mem_adv) begin
                    state_d = MIO_IDLE;
                end
            end
            default: begin
                state_d = MIO_IDLE;
            end
        endcase

        // A flush aborts the access; a pending result is still acknowledged so the channel frees up
        if (bus.pipe_flush) begin
            state_d = MIO_IDLE;
            cnt_d   = '0;
            err_d   = 1'b0;
            start_c = '0;
            clear_c = (state_q == MIO_WAIT_RDY) ? ch_oh : '0;
        end
    end

    assign bus.io_start  = start_c;
    assign bus.io_clear  = clear_c;
    assign bus.io_wdata  = wdata_q;
    assign bus.data_out  = data_out_c;
    assign bus.stall     = stall_c;
    assign bus.flush_out = stall_c;
    assign bus.io_err    = io_err_c;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// tb/tb_mem_io_ctrl.sv - self-checking bench for mem_io_ctrl with a result scoreboard
module tb_mem_io_ctrl;
    localparam int          W       = 32;
    localparam int          NC      = 4;
    localparam int          CB      = 2;
    localparam int          TMO     = 8;
    localparam logic [31:0] EXP_ERR = 32'hDEADBEEF;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_io_ctrl_if #(.WIDTH(W), .N_CH(NC), .CH_BITS(CB)) bus ();

    mem_io_ctrl #(
        .WIDTH   (W),
        .N_CH    (NC),
        .CH_BITS (CB),
        .TIMEOUT (TMO),
        .ERR_VAL (EXP_ERR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid    = 1'b0;
        bus.req_is_dmem  = 2'b00;
        bus.req_is_io    = 1'b0;
        bus.req_is_state = 1'b0;
        bus.req_ch       = '0;
        bus.wdata        = '0;
        bus.mem_adv      = 1'b0;
        bus.pipe_flush   = 1'b0;
        bus.dc_ready     = 1'b1;
        bus.dc_rdata     = '0;
        bus.io_busy      = '0;
        bus.io_ready     = '0;
        bus.io_rdata     = '0;
    endtask

    task automatic io_load_req(input int ch, input logic [31:0] wd);
        bus.req_valid    = 1'b1;
        bus.req_is_dmem  = 2'b01;
        bus.req_is_io    = 1'b1;
        bus.req_is_state = 1'b0;
        bus.req_ch       = CB'(ch);
        bus.wdata        = wd;
        bus.mem_adv      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #12;
        checks++;
        if ({bus.io_start, bus.io_clear, bus.stall, bus.flush_out, bus.io_err} !== '0)
            begin errors++; $display("FAIL reset_ctl: got %b expected 0", {bus.io_start, bus.io_clear, bus.stall, bus.flush_out, bus.io_err}); end
        checks++;
        if (bus.data_out !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.data_out); end
        @(posedge clk);
        #1 rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_dcache();
        exp_t e;
        int   stall_n = 0;
        bit   done = 0;
        bus.req_valid   = 1'b1;
        bus.req_is_dmem = 2'b01;
        bus.req_is_io   = 1'b0;
        bus.dc_rdata    = 32'h12345678;
        sb.push_back('{1'b0, 32'h12345678});
        for (int c = 0; c < 10 && !done; c++) begin
            bus.dc_ready = (c >= 3);
            #5;
            checks++;
            if (bus.flush_out !== bus.stall) begin errors++; $display("FAIL dc_flush_out: got %b expected %b", bus.flush_out, bus.stall); end
            if (bus.stall === 1'b1) stall_n++;
            else begin
                done = 1;
                e = sb.pop_front();
                checks++;
                if (bus.data_out !== e.data) begin errors++; $display("FAIL dc_data: got %h expected %h", bus.data_out, e.data); end
            end
            next_cycle();
        end
        checks++;
        if (stall_n != 3 || !done) begin errors++; $display("FAIL dc_stall_cycles: got %0d expected 3 (done=%0d)", stall_n, done); end
        idle_inputs();
    endtask

    task automatic test_status();
        bus.req_valid    = 1'b1;
        bus.req_is_io    = 1'b1;
        bus.req_is_state = 1'b1;
        bus.req_ch       = 2'd2;
        bus.io_busy      = 4'b0100;
        bus.io_ready     = 4'b1011;
        #5;
        checks++;
        if (bus.data_out !== 32'h2 || bus.stall !== 1'b0)
            begin errors++; $display("FAIL status_ch2: got data %h stall %b expected 00000002 stall 0", bus.data_out, bus.stall); end
        bus.req_ch   = 2'd0;
        bus.io_busy  = 4'b1110;
        bus.io_ready = 4'b0001;
        #1;
        checks++;
        if (bus.data_out !== 32'h1 || bus.stall !== 1'b0)
            begin errors++; $display("FAIL status_ch0: got data %h stall %b expected 00000001 stall 0", bus.data_out, bus.stall); end
        next_cycle();
        idle_inputs();
    endtask

    // One IO load from request to DONE hold and mem_adv; other channels carry busy/ready/data noise
    task automatic run_io(input int ch, input logic [31:0] wd, input logic [31:0] rd,
                          input int busy_cyc, input int rdy);
        exp_t            e, got;
        int              start_cyc = -1, clear_cyc = -1, done_cyc = -1;
        int              stall_n = 0, n_start = 0, n_clear = 0;
        int              exp_start, exp_clear, exp_done, exp_n;
        logic [NC-1:0]   oh;
        oh = '0;
        oh[ch] = 1'b1;
        if (busy_cyc > TMO + 1) begin
            exp_start = -1; exp_clear = -1; exp_done = TMO + 2; exp_n = 0;
            e = '{1'b1, EXP_ERR};
        end else begin
            exp_start = (busy_cyc == 0) ? 1 : busy_cyc + 1;
            exp_clear = exp_start + 1 + ((rdy < 0) ? TMO : rdy);
            exp_done  = exp_clear + 1;
            exp_n     = 1;
            e = (rdy < 0) ? '{1'b1, EXP_ERR} : '{1'b0, rd};
        end
        sb.push_back(e);
        io_load_req(ch, wd);
        for (int c = 0; c < 40 && done_cyc < 0; c++) begin
            bus.io_busy      = ~oh;
            bus.io_busy[ch]  = (c < busy_cyc);
            bus.io_ready     = ~oh;
            bus.io_ready[ch] = (rdy >= 0 && start_cyc >= 0 && c == start_cyc + 1 + rdy);
            bus.io_rdata     = {NC{32'h0BAD0BAD}};
            bus.io_rdata[ch*W +: W] = rd;
            #5;
            if (bus.io_start !== '0) begin
                n_start++; start_cyc = c; checks++;
                if (bus.io_start !== oh || bus.io_wdata !== wd)
                    begin errors++; $display("FAIL io_start: got %b/%h expected %b/%h", bus.io_start, bus.io_wdata, oh, wd); end
            end
            if (bus.io_clear !== '0) begin
                n_clear++; clear_cyc = c; checks++;
                if (bus.io_clear !== oh) begin errors++; $display("FAIL io_clear: got %b expected %b", bus.io_clear, oh); end
            end
            checks++;
            if (bus.flush_out !== bus.stall) begin errors++; $display("FAIL io_flush_out: got %b expected %b", bus.flush_out, bus.stall); end
            if (bus.stall === 1'b1) stall_n++;
            else begin
                done_cyc = c;
                got = sb.pop_front();
                checks++;
                if (bus.data_out !== got.data || bus.io_err !== got.err)
                    begin errors++; $display("FAIL io_result: got %h err %b expected %h err %b", bus.data_out, bus.io_err, got.data, got.err); end
            end
            next_cycle();
        end
        checks++;
        if (done_cyc != exp_done) begin errors++; $display("FAIL io_done_cycle: got %0d expected %0d", done_cyc, exp_done); end
        checks++;
        if (start_cyc != exp_start || n_start != exp_n)
            begin errors++; $display("FAIL io_start_cycle: got %0d (x%0d) expected %0d (x%0d)", start_cyc, n_start, exp_start, exp_n); end
        checks++;
        if (clear_cyc != exp_clear || n_clear != exp_n)
            begin errors++; $display("FAIL io_clear_cycle: got %0d (x%0d) expected %0d (x%0d)", clear_cyc, n_clear, exp_clear, exp_n); end
        checks++;
        if (stall_n != exp_done) begin errors++; $display("FAIL io_stall_cycles: got %0d expected %0d", stall_n, exp_done); end
        bus.io_ready = ~oh;
        for (int h = 0; h < 2; h++) begin
            #5;
            checks++;
            if (bus.stall !== 1'b0 || bus.data_out !== e.data || bus.io_err !== e.err || bus.io_start !== '0)
                begin errors++; $display("FAIL done_hold: got stall %b data %h err %b start %b expected 0 %h %b 0", bus.stall, bus.data_out, bus.io_err, bus.io_start, e.data, e.err); end
            next_cycle();
        end
        bus.mem_adv = 1'b1;
        next_cycle();
        bus.mem_adv = 1'b0;
    endtask

    task automatic test_io_load();     run_io(1, 32'h11110000, 32'hA5A5A5A5, 0, 0);  endtask
    task automatic test_busy_wait();   run_io(3, 32'h33330000, 32'h0C0FFEE3, 5, 0);  endtask
    task automatic test_ready_timeout(); run_io(2, 32'h22220000, 32'h12121212, 0, -1); endtask
    task automatic test_busy_timeout();  run_io(0, 32'h00000007, 32'h55555555, 20, 0); endtask

    task automatic test_back_to_back();
        run_io(0, 32'hAAAA0001, 32'h01020304, 0, 2);
        run_io(2, 32'hAAAA0002, 32'hF0E0D0C0, 1, 0);
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_flush();
        idle_inputs();
        io_load_req(0, 32'h0F0F0F0F);
        #5;
        checks++;
        if (bus.stall !== 1'b1) begin errors++; $display("FAIL flush_pre_stall: got %b expected 1", bus.stall); end
        next_cycle();
        #5;
        checks++;
        if (bus.io_start !== 4'b0001) begin errors++; $display("FAIL flush_pre_start: got %b expected 0001", bus.io_start); end
        next_cycle();
        bus.pipe_flush = 1'b1;
        #5;
        checks++;
        if (bus.io_clear !== 4'b0001 || bus.io_start !== '0)
            begin errors++; $display("FAIL flush_wait_rdy_clear: got clear %b start %b expected 0001 0000", bus.io_clear, bus.io_start); end
        next_cycle();
        bus.pipe_flush = 1'b0;
        bus.req_valid  = 1'b0;
        #5;
        checks++;
        if (bus.stall !== 1'b0 || bus.data_out !== '0 || bus.io_err !== 1'b0 || bus.io_clear !== '0)
            begin errors++; $display("FAIL flush_after: got stall %b data %h err %b clear %b expected 0", bus.stall, bus.data_out, bus.io_err, bus.io_clear); end
        next_cycle();
        io_load_req(2, 32'h0);
        next_cycle();
        bus.pipe_flush = 1'b1;
        #5;
        checks++;
        if (bus.io_start !== '0) begin errors++; $display("FAIL flush_start_suppress: got %b expected 0000", bus.io_start); end
        next_cycle();
        bus.pipe_flush = 1'b0;
        bus.req_valid  = 1'b0;
        #5;
        checks++;
        if (bus.stall !== 1'b0 || bus.io_start !== '0 || bus.io_clear !== '0)
            begin errors++; $display("FAIL flush_start_after: got stall %b start %b clear %b expected 0", bus.stall, bus.io_start, bus.io_clear); end
        next_cycle();
    endtask

    task automatic test_async_reset();
        idle_inputs();
        io_load_req(3, 32'h3);
        bus.io_busy = 4'b1000;
        next_cycle();
        next_cycle();
        #5;
        checks++;
        if (bus.stall !== 1'b1) begin errors++; $display("FAIL rst_pre_stall: got %b expected 1", bus.stall); end
        #1;
        rst = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        checks++;
        if ({bus.io_start, bus.io_clear, bus.stall, bus.flush_out, bus.io_err} !== '0 || bus.data_out !== '0)
            begin errors++; $display("FAIL rst_async: got ctl %b data %h expected 0", {bus.io_start, bus.io_clear, bus.stall, bus.flush_out, bus.io_err}, bus.data_out); end
        next_cycle();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        run_io(1, 32'h77777777, 32'h89ABCDEF, 0, 1);
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_dcache();
        test_status();
        test_io_load();
        test_busy_wait();
        test_ready_timeout();
        test_busy_timeout();
        test_back_to_back();
        test_flush();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d expected 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
